cache_sa: RTL and testbench

Parametrised N-way set-associative, write-back, write-allocate cache with true-LRU replacement. It generalises the direct-mapped `cache_data` in sets, ways, block size and memory latency. It sits between the requester and the block-wide `mem` model and keeps the same request, memory and response signal set.

---
 rtl/cache_sa_if.sv | 31 +++
 rtl/cache_sa.sv | 240 ++++++++++++++++++++++++
 tb/tb_cache_sa.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_sa_if.sv
// Request/response and block-memory signal bundle for cache_sa.
// The master drives requests and returns memory blocks; the slave is the cache.
interface cache_sa_if #(
  parameter int unsigned PA_WIDTH  = 32,
  parameter int unsigned WRD_WIDTH = 32,
  parameter int unsigned BLK_WIDTH = 512
);
  logic                 rd_en;
  logic                 wr_en;
  logic [PA_WIDTH-1:0]  addr;
  logic [WRD_WIDTH-1:0] data_wr;
  logic [BLK_WIDTH-1:0] mem_rd_blk;
  logic [PA_WIDTH-1:0]  mem_addr;
  logic                 mem_rd_en;
  logic                 mem_wr_en;
  logic [BLK_WIDTH-1:0] mem_wr_blk;
  logic                 hit;
  logic [WRD_WIDTH-1:0] word_out;
  logic [7:0]           byte_out;
  logic                 rdy;

  modport master (
    output rd_en, wr_en, addr, data_wr, mem_rd_blk,
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_blk, hit, word_out, byte_out, rdy
  );

  modport slave (
    input  rd_en, wr_en, addr, data_wr, mem_rd_blk,
    output mem_addr, mem_rd_en, mem_wr_en, mem_wr_blk, hit, word_out, byte_out, rdy
  );
endinterface

// File: rtl/cache_sa.sv
// N-way set-associative write-back, write-allocate cache with true-LRU replacement
// and a block-wide memory port with configurable read latency.
module cache_sa #(
  parameter int unsigned PA_WIDTH  = 32,
  parameter int unsigned WRD_WIDTH = 32,
  parameter int unsigned BLK_WIDTH = 512,
  parameter int unsigned SETS      = 16,
  parameter int unsigned WAYS      = 2,
  parameter int unsigned MEM_LAT   = 1
) (
  input logic       clk,
  input logic       rst,
  cache_sa_if.slave bus
);

  localparam int unsigned OFF_W  = $clog2(BLK_WIDTH / 8);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = PA_WIDTH - OFF_W - IDX_W;
  localparam int unsigned BSEL_W = $clog2(WRD_WIDTH / 8);
  localparam int unsigned WSEL_W = OFF_W - BSEL_W;
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {StIdle, StLookup, StWriteback, StRefill, StResp} state_e;

  state_e state_q, state_d;

  logic [SETS-1:0][WAYS-1:0] valid_q;
  logic [SETS-1:0][WAYS-1:0] dirty_q;
  logic [TAG_W-1:0]          tag_q  [SETS][WAYS];
  logic [BLK_WIDTH-1:0]      data_q [SETS][WAYS];

  logic [PA_WIDTH-1:0]  addr_q;
  logic [WRD_WIDTH-1:0] wdata_q;
  logic                 is_wr_q;
  logic [WAY_W-1:0]     way_q;
  logic                 hit_pend_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 hit_q;
  logic [WRD_WIDTH-1:0] word_q;
  logic [7:0]           byte_q;

  logic [TAG_W-1:0]  tag_f;
  logic [IDX_W-1:0]  idx_f;
  logic [WSEL_W-1:0] wsel_f;
  logic [BSEL_W-1:0] bsel_f;

  assign tag_f  = addr_q[PA_WIDTH-1 -: TAG_W];
  assign idx_f  = addr_q[OFF_W +: IDX_W];
  assign wsel_f = addr_q[BSEL_W +: WSEL_W];
  assign bsel_f = addr_q[BSEL_W-1:0];

  logic             hit_any, inv_any, victim_dirty, refill_last;
  logic [WAY_W-1:0] hit_way, inv_way, lru_way, victim_way;
  int unsigned      wsel_off;
  logic [WRD_WIDTH-1:0] resp_word;
  logic [7:0]           resp_byte;

  // Descending scan so the lowest-index match / invalid way wins.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (valid_q[idx_f][w] && (tag_q[idx_f][w] == tag_f)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx_f][w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  if (WAYS > 1) begin : g_lru
    logic [SETS-1:0][WAYS-1:0][WAY_W-1:0] age_q;

    always_comb begin
      logic [WAY_W-1:0] max_age;
      lru_way = '0;
      max_age = age_q[idx_f][0];
      for (int w = 1; w < int'(WAYS); w++) begin
        if (age_q[idx_f][w] > max_age) begin
          max_age = age_q[idx_f][w];
          lru_way = WAY_W'(w);
        end
      end
    end

    // Accessed way becomes youngest; only ways younger than it age by one.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < int'(SETS); s++) begin
          for (int w = 0; w < int'(WAYS); w++) begin
            age_q[s][w] <= WAY_W'(w);
          end
        end
      end else if (state_q == StResp) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          if (WAY_W'(w) == way_q) begin
            age_q[idx_f][w] <= '0;
          end else if (age_q[idx_f][w] < age_q[idx_f][way_q]) begin
            age_q[idx_f][w] <= age_q[idx_f][w] + 1'b1;
          end
        end
      end
    end
  end else begin : g_no_lru
    assign lru_way = '0;
  end

  assign victim_way   = inv_any ? inv_way : lru_way;
  assign victim_dirty = valid_q[idx_f][victim_way] && dirty_q[idx_f][victim_way];
  assign refill_last  = (cnt_q == LAT_LAST);

  always_comb begin
    wsel_off  = int'(wsel_f) * WRD_WIDTH;
    resp_word = is_wr_q ? wdata_q : data_q[idx_f][way_q][wsel_off +: WRD_WIDTH];
    resp_byte = resp_word[int'(bsel_f) * 8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (bus.rd_en || bus.wr_en) state_d = StLookup;
      StLookup: begin
        if (hit_any) begin
          state_d = StResp;
        end else if (victim_dirty) begin
          state_d = StWriteback;
        end else begin
          state_d = StRefill;
        end
      end
      StWriteback: state_d = StRefill;
      StRefill:    if (refill_last) state_d = StResp;
      StResp:      state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.mem_rd_en  = 1'b0;
    bus.mem_wr_en  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wr_blk = '0;
    bus.rdy        = 1'b0;
    bus.hit        = hit_q;
    bus.word_out   = word_q;
    bus.byte_out   = byte_q;
    unique case (state_q)
      StWriteback: begin
        bus.mem_wr_en  = 1'b1;
        bus.mem_addr   = {tag_q[idx_f][way_q], idx_f, {OFF_W{1'b0}}};
        bus.mem_wr_blk = data_q[idx_f][way_q];
      end
      StRefill: begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = {tag_f, idx_f, {OFF_W{1'b0}}};
      end
      StResp: begin
        bus.rdy      = 1'b1;
        bus.hit      = hit_pend_q;
        bus.word_out = resp_word;
        bus.byte_out = resp_byte;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      is_wr_q    <= 1'b0;
      way_q      <= '0;
      hit_pend_q <= 1'b0;
      cnt_q      <= '0;
      hit_q      <= 1'b0;
      word_q     <= '0;
      byte_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.rd_en || bus.wr_en) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.data_wr;
            is_wr_q <= bus.wr_en;
          end
        end
        StLookup: begin
          way_q      <= hit_any ? hit_way : victim_way;
          hit_pend_q <= hit_any;
          cnt_q      <= '0;
        end
        StRefill: cnt_q <= cnt_q + 1'b1;
        StResp: begin
          hit_q  <= hit_pend_q;
          word_q <= resp_word;
          byte_q <= resp_byte;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (state_q == StRefill && refill_last) begin
      valid_q[idx_f][way_q] <= 1'b1;
      dirty_q[idx_f][way_q] <= 1'b0;
    end else if (state_q == StResp && is_wr_q) begin
      dirty_q[idx_f][way_q] <= 1'b1;
    end
  end

  // Payload arrays need no reset; valid_q gates every use.
  always_ff @(posedge clk) begin
    if (state_q == StRefill && refill_last) begin
      data_q[idx_f][way_q] <= bus.mem_rd_blk;
      tag_q[idx_f][way_q]  <= tag_f;
    end else if (state_q == StResp && is_wr_q) begin
      data_q[idx_f][way_q][wsel_off +: WRD_WIDTH] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_cache_sa.sv
// Scoreboarded bench for cache_sa: expected responses are queued at issue time and
// popped when rdy pulses; memory is a block model where each word equals its address.
module tb_cache_sa;

  typedef struct {
    logic        hit;
    logic [31:0] word;
    logic [7:0]  byt;
    int          lat;
  } exp_t;

  logic clk;
  logic rst;
  cache_sa_if bus ();

  cache_sa u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;
  int rd_cycles = 0;
  int wr_cycles = 0;
  int both_cnt = 0;
  logic [31:0]  rd_addr = '0;
  logic [31:0]  wb_addr = '0;
  logic [511:0] wb_blk = '0;
  logic [511:0] mem_store [int unsigned];

  function automatic logic [511:0] mem_blk(input logic [31:0] a);
    logic [31:0]  base;
    logic [511:0] b;
    base = {a[31:6], 6'b0};
    if (mem_store.exists(base)) return mem_store[base];
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = base + 32'(i * 4);
    return b;
  endfunction

  // Memory model and enable monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_wr_en) begin
      mem_store[{bus.mem_addr[31:6], 6'b0}] = bus.mem_wr_blk;
      wr_cycles++;
      wb_addr = bus.mem_addr;
      wb_blk  = bus.mem_wr_blk;
    end
    if (bus.mem_rd_en) begin
      rd_cycles++;
      rd_addr = bus.mem_addr;
    end
    if (bus.mem_rd_en && bus.mem_wr_en) both_cnt++;
    bus.mem_rd_blk = mem_blk(bus.mem_addr);
  end

  task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input bit pulse, output logic h, output logic [31:0] w,
                       output logic [7:0] b, output int lat, output int drd, output int dwr);
    int rd0, wr0;
    bit got;
    @(negedge clk);
    bus.rd_en = rd; bus.wr_en = wr; bus.addr = a; bus.data_wr = d;
    rd0 = rd_cycles; wr0 = wr_cycles;
    @(posedge clk);
    @(negedge clk);
    bus.rd_en = pulse; bus.wr_en = 1'b0;
    lat = 1; got = 1'b0; h = 1'bx; w = 'x; b = 'x;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      bus.rd_en = 1'b0;
      if (bus.rdy) begin
        got = 1'b1; h = bus.hit; w = bus.word_out; b = bus.byte_out;
      end
    end
    if (!got) lat = -1;
    drd = rd_cycles - rd0;
    dwr = wr_cycles - wr0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.addr = '0; bus.data_wr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({bus.rdy, bus.hit, bus.mem_rd_en, bus.mem_wr_en} !== 4'b0)
      $display("FAIL reset_ctrl: rdy/hit/rd/wr=%b required 0000",
               {bus.rdy, bus.hit, bus.mem_rd_en, bus.mem_wr_en});
    else n_pass++;
    n_chk++;
    if (bus.word_out !== 32'h0 || bus.byte_out !== 8'h0)
      $display("FAIL reset_data: word=%h byte=%h required 0", bus.word_out, bus.byte_out);
    else n_pass++;
    n_chk++;
    if (bus.mem_addr !== 32'h0 || bus.mem_wr_blk !== 512'h0)
      $display("FAIL reset_mem: mem_addr=%h required 0", bus.mem_addr);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_cold_read();
    exp_t e; logic h; logic [31:0] w; logic [7:0] b; int lat, drd, dwr;
    sb.push_back('{1'b0, 32'h0, 8'h0, 3});
    issue(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, h, w, b, lat, drd, dwr);
    e = sb.pop_front();
    n_chk++;
    if (h !== e.hit || w !== e.word || b !== e.byt || lat != e.lat)
      $display("FAIL cold_read: hit=%b word=%h byte=%h lat=%0d required %b %h %h %0d",
               h, w, b, lat, e.hit, e.word, e.byt, e.lat);
    else n_pass++;
    n_chk++;
    if (drd != 1 || dwr != 0 || rd_addr !== 32'h0)
      $display("FAIL cold_mem: rd_cycles=%0d wr_cycles=%0d addr=%h required 1 0 0", drd, dwr, rd_addr);
    else n_pass++;
  endtask

  task automatic test_hits();
    logic [31:0] addrs [4] = '{32'h15, 32'h19, 32'h1D, 32'h21};
    logic [31:0] words [4] = '{32'h14, 32'h18, 32'h1C, 32'h20};
    exp_t e; logic h; logic [31:0] w; logic [7:0] b; int lat, drd, dwr;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{1'b1, words[i], 8'h00, 2});
      issue(1'b1, 1'b0, addrs[i], 32'h0, 1'b0, h, w, b, lat, drd, dwr);
      e = sb.pop_front();
      n_chk++;
      if (h !== e.hit || w !== e.word || b !== e.byt || lat != e.lat || drd != 0 || dwr != 0)
        $display("FAIL hit_read[%0d]: hit=%b word=%h byte=%h lat=%0d rd=%0d wr=%0d required %b %h %h %0d 0 0",
                 i, h, w, b, lat, drd, dwr, e.hit, e.word, e.byt, e.lat);
      else n_pass++;
    end
  endtask

  task automatic test_write_hit();
    bit          wr_t [2] = '{1'b1, 1'b0};
    logic [31:0] a_t  [2] = '{32'h04, 32'h07};
    logic [7:0]  b_t  [2] = '{8'hEF, 8'hDE};
    exp_t e; logic h; logic [31:0] w; logic [7:0] b; int lat, drd, dwr;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{1'b1, 32'hDEADBEEF, b_t[i], 2});
      issue(!wr_t[i], wr_t[i], a_t[i], 32'hDEADBEEF, 1'b0, h, w, b, lat, drd, dwr);
      e = sb.pop_front();
      n_chk++;
      if (h !== e.hit || w !== e.word || b !== e.byt || lat != e.lat || dwr != 0)
        $display("FAIL write_hit[%0d]: hit=%b word=%h byte=%h lat=%0d wr=%0d required %b %h %h %0d 0",
                 i, h, w, b, lat, dwr, e.hit, e.word, e.byt, e.lat);
      else n_pass++;
    end
  endtask

  task automatic test_eviction();
    logic [31:0] a_t   [3] = '{32'h400, 32'h800, 32'h04};
    logic [31:0] w_t   [3] = '{32'h400, 32'h800, 32'hDEADBEEF};
    logic [7:0]  b_t   [3] = '{8'h00, 8'h00, 8'hEF};
    int          lat_t [3] = '{3, 4, 3};
    int          wb_t  [3] = '{0, 1, 0};
    exp_t e; logic h; logic [31:0] w; logic [7:0] b; int lat, drd, dwr;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{1'b0, w_t[i], b_t[i], lat_t[i]});
      issue(1'b1, 1'b0, a_t[i], 32'h0, 1'b0, h, w, b, lat, drd, dwr);
      e = sb.pop_front();
      n_chk++;
      if (h !== e.hit || w !== e.word || b !== e.byt || lat != e.lat || drd != 1 || dwr != wb_t[i])
        $display("FAIL evict[%0d]: hit=%b word=%h byte=%h lat=%0d rd=%0d wr=%0d required %b %h %h %0d 1 %0d",
                 i, h, w, b, lat, drd, dwr, e.hit, e.word, e.byt, e.lat, wb_t[i]);
      else n_pass++;
      if (i == 1) begin
        n_chk++;
        if (wb_addr !== 32'h0 || wb_blk[63:32] !== 32'hDEADBEEF || wb_blk[31:0] !== 32'h0)
          $display("FAIL writeback: addr=%h word1=%h word0=%h required 0 deadbeef 0",
                   wb_addr, wb_blk[63:32], wb_blk[31:0]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_rd_wr_both();
    exp_t e; logic h; logic [31:0] w; logic [7:0] b; int lat, drd, dwr;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{1'b1, 32'h12345678, 8'h78, 2});
      issue(1'b1, (i == 0), 32'h08, (i == 0) ? 32'h12345678 : 32'h0, 1'b0, h, w, b, lat, drd, dwr);
      e = sb.pop_front();
      n_chk++;
      if (h !== e.hit || w !== e.word || b !== e.byt || lat != e.lat)
        $display("FAIL rd_wr_both[%0d]: hit=%b word=%h byte=%h lat=%0d required %b %h %h %0d",
                 i, h, w, b, lat, e.hit, e.word, e.byt, e.lat);
      else n_pass++;
    end
  endtask

  task automatic test_ignore_pulses();
    exp_t e; logic h; logic [31:0] w; logic [7:0] b; int lat, drd, dwr, extra;
    sb.push_back('{1'b0, 32'hC00, 8'h00, 3});
    issue(1'b1, 1'b0, 32'hC00, 32'h0, 1'b1, h, w, b, lat, drd, dwr);
    e = sb.pop_front();
    n_chk++;
    if (h !== e.hit || w !== e.word || b !== e.byt || lat != e.lat)
      $display("FAIL pulse_miss: hit=%b word=%h byte=%h lat=%0d required %b %h %h %0d",
               h, w, b, lat, e.hit, e.word, e.byt, e.lat);
    else n_pass++;
    extra = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.rdy) extra++;
    end
    n_chk++;
    if (extra != 0) $display("FAIL pulse_extra_rdy: got %0d pulses required 0", extra);
    else n_pass++;
    n_chk++;
    if (bus.word_out !== 32'hC00 || bus.hit !== 1'b0)
      $display("FAIL output_hold: word=%h hit=%b required 00000c00 0", bus.word_out, bus.hit);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int t1, t2, nrdy;
    t1 = -1; t2 = -1; nrdy = 0;
    sb.push_back('{1'b1, 32'h10, 8'h10, 2});
    sb.push_back('{1'b1, 32'h10, 8'h10, 2});
    @(negedge clk);
    bus.rd_en = 1'b1; bus.wr_en = 1'b0; bus.addr = 32'h10;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (bus.rdy) begin
        nrdy++;
        if (t1 < 0) t1 = c;
        else if (t2 < 0) t2 = c;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          n_chk++;
          if (bus.hit !== e.hit || bus.word_out !== e.word || bus.byte_out !== e.byt)
            $display("FAIL b2b_data: hit=%b word=%h byte=%h required %b %h %h",
                     bus.hit, bus.word_out, bus.byte_out, e.hit, e.word, e.byt);
          else n_pass++;
        end
      end
      if (t1 > 0 && c == t1 + 2) bus.rd_en = 1'b0;
    end
    bus.rd_en = 1'b0;
    n_chk++;
    if (t1 != 2 || t2 != 5 || nrdy != 2)
      $display("FAIL b2b_timing: first=%0d second=%0d pulses=%0d required 2 5 2", t1, t2, nrdy);
    else n_pass++;
  endtask

  task automatic test_reset_mid_refill();
    exp_t e; logic h; logic [31:0] w; logic [7:0] b; int lat, drd, dwr, stray;
    bit seen;
    @(negedge clk);
    bus.rd_en = 1'b1; bus.addr = 32'h1000;
    @(posedge clk);
    @(negedge clk);
    bus.rd_en = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(posedge clk); #1;
      if (bus.mem_rd_en) seen = 1'b1;
    end
    n_chk++;
    if (!seen) $display("FAIL refill_timeout: mem_rd_en=0 required 1 within 6 cycles");
    else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (bus.mem_rd_en !== 1'b0 || bus.rdy !== 1'b0)
      $display("FAIL rst_abort: mem_rd_en=%b rdy=%b required 0 0", bus.mem_rd_en, bus.rdy);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.rdy) stray++;
    end
    n_chk++;
    if (stray != 0) $display("FAIL rst_no_rdy: got %0d pulses required 0", stray);
    else n_pass++;
    sb.push_back('{1'b0, 32'h0, 8'h0, 3});
    issue(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, h, w, b, lat, drd, dwr);
    e = sb.pop_front();
    n_chk++;
    if (h !== e.hit || w !== e.word || b !== e.byt || lat != e.lat)
      $display("FAIL post_rst_read: hit=%b word=%h byte=%h lat=%0d required %b %h %h %0d",
               h, w, b, lat, e.hit, e.word, e.byt, e.lat);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_hits();
    test_write_hit();
    test_eviction();
    test_rd_wr_both();
    test_ignore_pulses();
    test_back_to_back();
    test_reset_mid_refill();
    n_chk++;
    if (both_cnt != 0) $display("FAIL enables_exclusive: both high %0d cycles required 0", both_cnt);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
